// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Keyboard replies and housekeeping bytes that never reach the core.
   localparam logic [7:0][7:0] PS2_IGNORE = {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                             8'hFC, 8'hFD, 8'hFE, 8'hFF};

   localparam int KEY_TOG = 10;
   localparam int KEY_PRS = 9;
   localparam int KEY_EXT = 8;

   function automatic logic ps2_is_ignored(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 8; i++)
         if (PS2_IGNORE[i] == b) hit = 1'b1;
      return hit;
   endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, stability filter and falling-edge strobe for one PS/2 line.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic line,
   output logic filt,
   output logic fall
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync <= 2'b11;
         filt <= 1'b1;
         cnt  <= '0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], line};
         fall <= 1'b0;
         if (sync[1] == filt)
            cnt <= '0;
         else if (cnt == CW'(FILTER_LEN - 1)) begin
            // Level flips only after FILTER_LEN disagreeing samples in a row.
            filt <= sync[1];
            cnt  <= '0;
            fall <= filt;
         end else
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/ps2_key_encoder.sv
// Raw PS/2 lines to the toggle-style 11-bit ps2_key event word.
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        rx_err
);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   logic          unused_clk_lvl, clk_fall, data_f, unused_data_fall;
   rx_state_e     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_err, ext, rel;
   logic [2:0]    skip;
   logic [WW-1:0] wdog;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk_sys(clk_sys), .reset(reset), .line(ps2_clk),
      .filt(unused_clk_lvl), .fall(clk_fall));

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk_sys(clk_sys), .reset(reset), .line(ps2_data),
      .filt(data_f), .fall(unused_data_fall));

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_err <= 1'b0;
         ext     <= 1'b0;
         rel     <= 1'b0;
         skip    <= '0;
         wdog    <= '0;
         ps2_key <= '0;
         rx_err  <= 1'b0;
      end else begin
         rx_err <= 1'b0;
         if (clk_fall) begin
            // A strobe always beats a simultaneous watchdog expiry.
            wdog <= '0;
            case (state)
               IDLE: if (!data_f) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  par_err <= 1'b0;
               end
               DATA: begin
                  shreg   <= {data_f, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_err <= ~(^{shreg, data_f});
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (data_f && !par_err) begin
                     if (skip != 3'd0)
                        skip <= skip - 1'b1;
                     else if (shreg == PS2_PAUSE)
                        skip <= 3'd7;
                     else if (shreg == PS2_EXT)
                        ext <= 1'b1;
                     else if (shreg == PS2_BRK)
                        rel <= 1'b1;
                     else begin
                        if (!ps2_is_ignored(shreg)) begin
                           ps2_key[KEY_TOG] <= ~ps2_key[KEY_TOG];
                           ps2_key[KEY_PRS] <= ~rel;
                           ps2_key[KEY_EXT] <= ext;
                           ps2_key[7:0]     <= shreg;
                        end
                        ext <= 1'b0;
                        rel <= 1'b0;
                     end
                  end else begin
                     rx_err <= 1'b1;
                     ext    <= 1'b0;
                     rel    <= 1'b0;
                     skip   <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (wdog == WW'(TIMEOUT_CYC - 1)) begin
               state  <= IDLE;
               wdog   <= '0;
               rx_err <= 1'b1;
               ext    <= 1'b0;
               rel    <= 1'b0;
               skip   <= '0;
            end else
               wdog <= wdog + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ps2_key_encoder.sv
// Vector table of PS/2 frames with a scoreboard on ps2_key updates, plus timeout/glitch/reset sequences.
module tb_ps2_key_encoder;
   localparam int FL   = 4;
   localparam int TO   = 400;
   localparam int HALF = 20;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        rx_err;

   ps2_key_encoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
      .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ps2_key(ps2_key), .rx_err(rx_err));

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [7:0]  code;
      bit          bad;
      bit          pub;
      logic [10:0] key;
      bit          err;
   } vec_t;

   vec_t        vecs [21];
   logic [10:0] expq [$];
   int          checks = 0, passes = 0;
   int          err_cnt = 0, err_cyc = 0, cyc = 0, last_fall = 0;
   logic [10:0] prev_key = '0;
   logic        prev_err = 1'b0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: every ps2_key change must match the next queued expectation.
   always @(negedge clk_sys) begin
      if (reset) begin
         prev_key = ps2_key;
         prev_err = 1'b0;
      end else begin
         if (rx_err) begin
            err_cnt++;
            err_cyc = cyc;
            if (prev_err) begin
               checks++;
               $display("FAIL rx_err_width: got 2 consecutive cycles expected 1");
            end
         end
         prev_err = rx_err;
         if (ps2_key !== prev_key) begin
            checks++;
            if (expq.size() == 0)
               $display("FAIL unexpected_update: got %0h expected no change from %0h", ps2_key, prev_key);
            else begin
               logic [10:0] e;
               e = expq.pop_front();
               if (ps2_key === e) passes++;
               else $display("FAIL key_update: got %0h expected %0h", ps2_key, e);
            end
            prev_key = ps2_key;
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         last_fall = cyc;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] code, input bit bad);
      logic par;
      par = ~(^code) ^ bad;
      send_bits({1'b1, par, code, 1'b0}, 11);
      ps2_data = 1'b1;
   endtask

   task automatic run_vec(input int i);
      int e0;
      e0 = err_cnt;
      if (vecs[i].pub) expq.push_back(vecs[i].key);
      send_frame(vecs[i].code, vecs[i].bad);
      wait_cyc(3 * HALF);
      check($sformatf("vec%0d_publish", i), expq.size(), 0);
      check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].err);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      int e0;
      vecs = '{
         '{8'h29, 0, 1, 11'h629, 0},
         '{8'hF0, 0, 0, 11'h000, 0},
         '{8'h29, 0, 1, 11'h029, 0},
         '{8'hE0, 0, 0, 11'h000, 0},
         '{8'h75, 0, 1, 11'h775, 0},
         '{8'hE0, 0, 0, 11'h000, 0},
         '{8'hF0, 0, 0, 11'h000, 0},
         '{8'h75, 0, 1, 11'h175, 0},
         '{8'h29, 1, 0, 11'h000, 1},
         '{8'h14, 0, 1, 11'h614, 0},
         '{8'h6B, 0, 1, 11'h26B, 0},
         '{8'hE1, 0, 0, 11'h000, 0},
         '{8'h14, 0, 0, 11'h000, 0},
         '{8'h77, 0, 0, 11'h000, 0},
         '{8'hE1, 0, 0, 11'h000, 0},
         '{8'hF0, 0, 0, 11'h000, 0},
         '{8'h14, 0, 0, 11'h000, 0},
         '{8'hF0, 0, 0, 11'h000, 0},
         '{8'h77, 0, 0, 11'h000, 0},
         '{8'hAA, 0, 0, 11'h000, 0},
         '{8'h1C, 0, 1, 11'h61C, 0}
      };

      wait_cyc(5);
      check("reset_key", ps2_key, 11'h000);
      check("reset_err", rx_err, 1'b0);
      reset = 1'b0;
      wait_cyc(20);
      check("post_reset_key", ps2_key, 11'h000);

      for (int i = 0; i < 10; i++) run_vec(i);

      // Partial frame: start bit + 4 data bits, then silence.
      e0 = err_cnt;
      send_bits(11'b000_0011_0100, 5);
      ps2_data = 1'b1;
      for (int k = 0; k < TO + 100 && err_cnt == e0; k++) wait_cyc(1);
      check("timeout_err_count", err_cnt - e0, 1);
      checks++;
      if (err_cnt != e0 && err_cyc - last_fall >= TO && err_cyc - last_fall <= TO + FL + 8) passes++;
      else $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", err_cyc - last_fall, TO, TO + FL + 8);
      check("timeout_key_kept", ps2_key, 11'h614);

      for (int i = 10; i < 21; i++) run_vec(i);

      // 3-cycle clock glitch with data low: would look like a start bit if it got through.
      e0 = err_cnt;
      ps2_data = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF);
      ps2_data = 1'b1;
      wait_cyc(TO + 60);
      check("glitch_no_err", err_cnt - e0, 0);
      check("glitch_key_kept", ps2_key, 11'h61C);

      // Reset in the middle of an E0-prefixed frame.
      send_frame(8'hE0, 0);
      send_bits(11'b000_0000_1010, 4);
      reset = 1'b1;
      wait_cyc(2);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(1);
      reset = 1'b0;
      wait_cyc(1);
      check("midreset_key", ps2_key, 11'h000);
      check("midreset_err", rx_err, 1'b0);
      e0 = err_cnt;
      wait_cyc(TO + 60);
      check("midreset_no_err", err_cnt - e0, 0);
      check("midreset_no_update", expq.size(), 0);
      expq.push_back(11'h605);
      send_frame(8'h05, 0);
      wait_cyc(3 * HALF);
      check("after_reset_publish", expq.size(), 0);
      check("after_reset_key", ps2_key, 11'h605);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/ps2_key_encoder.md
# ps2_key_encoder

Converts a raw PS/2 keyboard line (clock and data pins) into the 11-bit toggle-style `ps2_key` event word that core input decoders consume. It sits between a physical or bridged PS/2 port and the core's keyboard decoder. Its output has the same format a core decoder already accepts from `hps_io`: `{toggle, pressed, extended, code[7:0]}`. That lets a core take keys from a directly attached keyboard without HPS involvement.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical `clk_sys` samples required before a filtered PS/2 line changes level.
- `TIMEOUT_CYC`, default 24000: idle cycles allowed between PS/2 clock falling edges inside a frame. At 12 MHz this is 2 ms.

Ports:
- `clk_sys` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `ps2_key` out 11: bit 10 is the toggle, bit 9 is pressed (1 = make), bit 8 is extended (E0 prefix seen), bits 7:0 are the scan code.
- `rx_err` out 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
Line conditioning:
- Both lines pass through a 2-flop synchronizer, then a `FILTER_LEN` stability filter.
- A falling edge of filtered `ps2_clk` is a sample strobe. Data is read from filtered `ps2_data` on that strobe.

Frame receive FSM, states `IDLE`, `DATA`, `PARITY`, `STOP`:
- `IDLE`: on a strobe with data=0 (start bit), go to `DATA` and set bit count to 0. A strobe with data=1 is ignored and the FSM stays in `IDLE`.
- `DATA`: shift in 8 bits, LSB first. After bit 7, go to `PARITY`.
- `PARITY`: compute odd parity over the 8 data bits plus the parity bit. A mismatch sets an internal error flag. Go to `STOP`.
- `STOP`: return to `IDLE`.
  - data=1 and no error flag: deliver the byte to the byte handler.
  - otherwise: drop the byte, pulse `rx_err`, clear `ext`, `rel` and the skip counter.

Timeout:
- The watchdog counter runs in every state except `IDLE` and is cleared by every strobe.
- On reaching `TIMEOUT_CYC`: go to `IDLE`, drop the partial frame, pulse `rx_err`, clear `ext`, `rel` and the skip counter.

Byte handler, applied in priority order:
1. Skip counter nonzero: decrement it and drop the byte.
2. 0xE1: set skip counter to 7 (rest of the Pause sequence). Not published.
3. 0xE0: set `ext`. 0xF0: set `rel`. Neither is published.
4. 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF: dropped. `ext` and `rel` are cleared.
5. Any other byte: `ps2_key <= {~ps2_key[10], ~rel, ext, byte}`, then clear `ext` and `rel`.

## Timing
- Reset values: `ps2_key` = 11'h000, `rx_err` = 0, FSM in `IDLE`, `ext` = `rel` = 0, skip counter = 0, watchdog = 0, filter outputs = 1 (idle high).
- Strobe latency: one cycle after a raw falling edge has been stable for 2 + `FILTER_LEN` cycles.
- Publish latency: `ps2_key` updates exactly 1 `clk_sys` after the stop-bit strobe. The toggle changes exactly once per published event.
- `rx_err` asserts 1 cycle after the stop-bit strobe, or in the cycle the watchdog expires. It is never asserted for 2 consecutive cycles.
- Glitches shorter than `FILTER_LEN` samples produce no strobe.
- Reset takes priority over every other event. Reset mid-frame discards the frame and prefixes; nothing is published.
- A timeout expiring in the same cycle as a strobe: the strobe wins and the watchdog clears.

## Structure
Shared package `ps2_pkg`:
- FSM state enum.
- Byte constants `PS2_EXT` = 8'hE0, `PS2_BRK` = 8'hF0, `PS2_PAUSE` = 8'hE1.
- Ignored-byte list.
- Field index constants for `ps2_key`: `KEY_TOG` = 10, `KEY_PRS` = 9, `KEY_EXT` = 8.

Sub-module `ps2_line_filter`:
- Contains the synchronizer, stability filter and falling-edge detect.
- Instantiated once per line, with edge output used only for `ps2_clk`.

## Test plan
1. Frame 0x29 with correct parity, `ps2_key` previously 0: after the stop bit, `ps2_key` = {1,1,0,8'h29}; `rx_err` stays 0.
2. F0 then 29: exactly one update, `ps2_key` = {0,0,0,8'h29}; toggle flips once.
3. E0 75, then E0 F0 75: first gives {t,1,1,8'h75}, second gives {~t,0,1,8'h75}.
4. 0x29 with inverted parity bit: `ps2_key` unchanged and a single 1-cycle `rx_err` pulse. A following valid 0x14 publishes {~t,1,0,8'h14}.
5. Five bits of a frame, then silence: `rx_err` pulses `TIMEOUT_CYC` cycles after the last strobe. A following full 0x6B frame decodes as {~t,1,0,8'h6B}.
6. Each of these produces no `ps2_key` change and no `rx_err`:
   - Pause sequence E1 14 77 E1 F0 14 F0 77.
   - 0xAA.
   - A 3-cycle low glitch on `ps2_clk`.
   - `reset` asserted mid-frame. After release, `ps2_key` = 0 and the next 0x05 frame gives {1,1,0,8'h05}.
